data_sram_bridge: RTL and testbench
===================================

# data_sram_bridge

Converts the CPU's single-cycle data SRAM port (enable, byte write-enable, address, write data, read data) into a request/grant plus read-response bus for a multi-cycle data memory. Sits directly downstream of the CPU core's data SRAM port. Holds the pipeline with `cpu_stall` until the access completes. Supports one outstanding access; read data is registered and held for the CPU.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte strobes are `DATA_W/8`
- `TIMEOUT_CYC`, 255, watchdog limit in cycles (used only with `DATA_SRAM_BRIDGE_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock; all logic on the rising edge
- `reset` in 1: synchronous, active-high
- `cpu_en` in 1: access request from the CPU
- `cpu_wen` in 4: byte write enables; any bit set means a write, all zero means a read
- `cpu_addr` in ADDR_W: byte address
- `cpu_wdata` in DATA_W: write data
- `cpu_rdata` out DATA_W: read data, valid in DONE
- `cpu_stall` out 1: freezes the CPU pipeline
- `bus_req` out 1: bus request
- `bus_wr` out 1: 1 means write
- `bus_strb` out 4: byte strobes
- `bus_addr` out ADDR_W: word-aligned address (`[1:0]` forced to 0)
- `bus_wdata` out DATA_W: write data
- `bus_gnt` in 1: request accepted
- `bus_rvalid` in 1: read response valid
- `bus_rdata` in DATA_W: read response data
- `bus_err` out 1: sticky timeout flag (driven 0 without the macro)

## Operation
FSM states: IDLE, REQ, WAIT, DONE.

- **IDLE**
  - When `cpu_en`=1: capture `cpu_wen`, `cpu_addr` and `cpu_wdata` into request registers, then go to REQ.
  - `cpu_stall` = `cpu_en`, combinational.
- **REQ**
  - `bus_req`=1; `bus_*` fields are driven from the request registers.
  - On `bus_gnt`: a write goes to DONE; a read goes to WAIT.
  - Without `bus_gnt`: stay in REQ with fields held stable.
- **WAIT**
  - `bus_req`=0.
  - On `bus_rvalid`: latch `bus_rdata` into `cpu_rdata`, then go to DONE.
  - `bus_rvalid` is ignored in every other state.
- **DONE**
  - `cpu_stall`=0 for exactly one cycle, then go to IDLE.
  - `cpu_rdata` holds its value until the next read completes.
- **Stall rule:** `cpu_stall`=1 in REQ and WAIT; `cpu_stall`=0 in DONE.
- **CPU obligation:** the CPU holds its inputs stable while stalled. The bridge uses only the captured copy.
- **Back-to-back accesses:** a new `cpu_en` in the cycle after DONE starts a fresh capture. There is no bubble beyond the IDLE cycle.
- **Reset:**
  - State returns to IDLE from any state, including mid-access. An in-flight bus transaction is abandoned; the bus is required to be reset together with the bridge.
  - Reset values: `cpu_stall`=0, `bus_req`=0, `bus_wr`=0, `bus_strb`=0, `bus_addr`=0, `bus_wdata`=0, `cpu_rdata`=0, `bus_err`=0.

## Timing
- **Read, minimum latency:**
  - cycle 0: capture
  - cycle 1: REQ with `bus_gnt`=1
  - cycle 2: WAIT with `bus_rvalid`=1
  - cycle 3: DONE, stall released
  - Total: 3 stalled cycles (0–2).
- **Write, minimum latency:** cycle 0 capture, cycle 1 REQ with grant, cycle 2 DONE. Total: 2 stalled cycles.
- **Same-cycle events:** `bus_gnt` and `bus_rvalid` arriving in the same cycle while in REQ: only the grant is honoured; the response is expected later.
- **Output timing:** `bus_*` outputs are registered or derived from state only, with no combinational path from `bus_gnt`. `cpu_stall` has a combinational path from `cpu_en` (IDLE only).

## Configuration
Macro: `DATA_SRAM_BRIDGE_TIMEOUT_EN`.

- **Defined:**
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the count reaches `TIMEOUT_CYC`: go to DONE, `cpu_rdata`=32'hDEAD_BEEF (reads only), and `bus_err` is set.
  - `bus_err` stays set until `reset`.
- **Not defined:** no counter; the bridge waits indefinitely; `bus_err` is tied to 0.

## Structure
- **Shared package `bridge_pkg`:** state enum (IDLE/REQ/WAIT/DONE), the `TIMEOUT_RDATA` constant 32'hDEAD_BEEF, and a request struct {wr, strb, addr, wdata}.
- **Sub-module `bridge_watchdog`:** the timeout counter, with inputs clear, count and limit, and output expired. It is instantiated only under the macro.

## Test plan
- **Read, zero-wait:** `cpu_en`=1, `cpu_wen`=0, `cpu_addr`=0x1000_0006, with `bus_gnt` and `bus_rvalid` immediate and `bus_rdata`=0x1234_5678.
  - `bus_addr`=0x1000_0004; stall high for 3 cycles; `cpu_rdata`=0x1234_5678 in DONE.
- **Byte write:** `cpu_wen`=4'b0010, `cpu_wdata`=0xAABB_CCDD, grant after 4 cycles.
  - `bus_wr`=1 and `bus_strb`=4'b0010 held for 4 cycles; stall high for 6 cycles; no WAIT state.
- **Same-cycle grant and response:** `bus_gnt` and a spurious `bus_rvalid` in the same cycle in REQ, then `bus_rvalid` 2 cycles later with 0xCAFE_0001.
  - `cpu_rdata`=0xCAFE_0001 (the spurious response is ignored).
- **Reset mid-access:** `reset` asserted in WAIT.
  - Next cycle: state IDLE, `bus_req`=0, `cpu_stall`=0, `cpu_rdata`=0. A following read completes normally.
- **Back-to-back:** read then write on consecutive accesses.
  - Exactly one IDLE cycle between DONE and the second REQ.
- **Timeout (macro defined, `TIMEOUT_CYC`=8):** read, grant given, `bus_rvalid` never arrives.
  - DONE after 8 cycles counted from REQ entry; `cpu_rdata`=0xDEAD_BEEF; `bus_err`=1 and sticky.

Source files
------------

// File: rtl/bridge_pkg.sv
// bridge_pkg
//   Shared definitions for data_sram_bridge and bridge_watchdog:
//   - state_e        : bridge FSM states (IDLE, REQ, WAIT, DONE)
//   - TIMEOUT_RDATA  : read data returned to the CPU when a read times out
//   - req_t          : captured CPU request {wr, strb, addr, wdata}
//   The request struct is sized for the 32-bit data memory bus. The bridge's
//   ADDR_W/DATA_W parameters must match these widths.
package bridge_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_STRB_W = BUS_DATA_W / 8;

  localparam logic [BUS_DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [BUS_STRB_W-1:0] strb;
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/bridge_watchdog.sv
// bridge_watchdog
//   Cycle counter that flags an access which has been outstanding too long.
//   Only built when DATA_SRAM_BRIDGE_TIMEOUT_EN is defined.
//   Ports:
//     clk     : clock, rising edge
//     reset   : synchronous, active-high
//     clear   : restart the count at zero (asserted on the cycle before REQ)
//     count   : advance the count this cycle (bridge in REQ or WAIT)
//     limit   : number of counted cycles after which expired fires
//     expired : the current counted cycle is the limit-th one
`ifdef DATA_SRAM_BRIDGE_TIMEOUT_EN
module bridge_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             count,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_next;

  // One extra bit so the comparison cannot wrap.
  assign cnt_next = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // Fires in the cycle whose increment would reach the limit, so the
  // bridge leaves REQ/WAIT after exactly 'limit' counted cycles.
  assign expired = count && (cnt_next >= {1'b0, limit});

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_next[CNT_W-1:0];
    end
  end

endmodule
`endif

// File: rtl/data_sram_bridge.sv
// data_sram_bridge
//   Converts the CPU's single-cycle data SRAM port into a request/grant plus
//   read-response bus for a multi-cycle data memory. One access outstanding;
//   the CPU is held with cpu_stall until the access completes.
//   Optional feature macro: DATA_SRAM_BRIDGE_TIMEOUT_EN (watchdog that ends a
//   stuck access after TIMEOUT_CYC cycles and sets sticky bus_err).
//   Ports:
//     clk, reset            : clock and synchronous active-high reset
//     cpu_en/wen/addr/wdata : CPU access request (wen != 0 means write)
//     cpu_rdata             : registered read data, valid in DONE and held
//     cpu_stall             : pipeline freeze
//     bus_req/wr/strb/addr/wdata : memory request, addr word aligned
//     bus_gnt               : request accepted
//     bus_rvalid/rdata      : read response
//     bus_err               : sticky timeout flag (0 without the macro)
module data_sram_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic [3:0]        cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_strb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  state_e state_q, state_d;
  req_t   req_q;
  logic   capture;
  logic   expired;
  logic   rsp_take;
  logic   abort;
  logic   unused_ok;

  assign capture = (state_q == IDLE) && cpu_en;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef DATA_SRAM_BRIDGE_TIMEOUT_EN
  localparam int               CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic err_q;

  bridge_watchdog #(
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (capture),
    .count   ((state_q == REQ) || (state_q == WAIT)),
    .limit   (LIMIT),
    .expired (expired)
  );

  // Sticky until reset so software can see that an access was lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (abort) begin
      err_q <= 1'b1;
    end
  end

  assign bus_err   = err_q;
  assign unused_ok = ^req_q.addr[1:0];
`else
  assign expired   = 1'b0;
  assign bus_err   = 1'b0;
  assign unused_ok = ^{req_q.addr[1:0], TIMEOUT_CYC[0]};
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves an output
    // unassigned and no latch is inferred.
    state_d   = state_q;
    bus_req   = 1'b0;
    cpu_stall = 1'b0;
    rsp_take  = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cpu_stall = cpu_en;
        if (cpu_en) state_d = REQ;
      end
      REQ: begin
        bus_req   = 1'b1;
        cpu_stall = 1'b1;
        // bus_rvalid is ignored here even when it coincides with the grant.
        if (bus_gnt) begin
          state_d = req_q.wr ? DONE : WAIT;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        cpu_stall = 1'b1;
        // A response arriving on the last counted cycle still wins.
        if (bus_rvalid) begin
          rsp_take = 1'b1;
          state_d  = DONE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and read data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      cpu_rdata <= '0;
    end else begin
      if (capture) begin
        req_q <= '{wr: |cpu_wen, strb: cpu_wen, addr: cpu_addr, wdata: cpu_wdata};
      end
      if (rsp_take) begin
        cpu_rdata <= bus_rdata;
      end else if (abort && !req_q.wr) begin
        cpu_rdata <= TIMEOUT_RDATA;
      end
    end
  end

  // Bus fields come straight from the captured request: stable through REQ
  // and free of any combinational path from bus_gnt.
  assign bus_wr    = req_q.wr;
  assign bus_strb  = req_q.strb;
  assign bus_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
  assign bus_wdata = req_q.wdata;

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge
//   Directed testbench for data_sram_bridge. The bench plays both the CPU and
//   the data memory; expected values are hand-computed constants.
//   With DATA_SRAM_BRIDGE_TIMEOUT_EN defined it also exercises the watchdog
//   (TIMEOUT_CYC = 8).
module tb_data_sram_bridge;
  import bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_strb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_count <= cyc_count + 1;

  data_sram_bridge #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_en     (cpu_en),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .bus_req    (bus_req),
    .bus_wr     (bus_wr),
    .bus_strb   (bus_strb),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One CPU access with a scripted memory. The grant is given on REQ cycle
  // number gnt_wait (0 = first), the response on WAIT cycle number rv_wait
  // (-1 = never). With spurious set, a bogus response accompanies the grant.
  // Returns on the cycle after DONE, in IDLE with cpu_en low.
  task automatic access(
    input  string       name,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] exp_baddr,
    input  logic        exp_wr,
    input  int          gnt_wait,
    input  int          rv_wait,
    input  logic [31:0] rdata,
    input  logic        spurious,
    output int          stalls,
    output int          req_n,
    output int          wait_n,
    output logic [31:0] got_rdata,
    output int unsigned done_cyc,
    output int unsigned first_req_cyc
  );
    bit granted = 1'b0;
    bit done    = 1'b0;
    stalls        = 0;
    req_n         = 0;
    wait_n        = 0;
    got_rdata     = '0;
    done_cyc      = 0;
    first_req_cyc = 0;
    cpu_en    = 1'b1;
    cpu_wen   = wen;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    #1;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      if (bus_req) begin
        if (req_n == 0) begin
          first_req_cyc = cyc_count;
          check({name, "/bus_addr"},  bus_addr,  exp_baddr);
          check({name, "/bus_wdata"}, bus_wdata, wdata);
        end
        check({name, "/bus_wr"},   bus_wr,   exp_wr);
        check({name, "/bus_strb"}, bus_strb, wen);
        if (req_n == gnt_wait) begin
          bus_gnt = 1'b1;
          granted = 1'b1;
          if (spurious) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hBAD0_0BAD;
          end
        end
        req_n++;
      end else if (cpu_stall && granted) begin
        if (wait_n == rv_wait) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rdata;
        end
        wait_n++;
      end else if (!cpu_stall && cyc > 0) begin
        got_rdata = cpu_rdata;
        done_cyc  = cyc_count;
        done      = 1'b1;
        cpu_en    = 1'b0;
      end
      if (cpu_stall) stalls++;
      step();
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    if (!done) check({name, "/completed"}, 64'd0, 64'd1);
  endtask

  initial begin
    int          stalls, req_n, wait_n;
    int unsigned done_cyc, first_req_cyc, done_cyc_a, first_req_b;
    logic [31:0] got;

    reset      = 1'b1;
    cpu_en     = 1'b0;
    cpu_wen    = '0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    step();
    step();

    // Reset values
    check("rst/state",     dut.state_q, IDLE);
    check("rst/cpu_stall", cpu_stall, 1'b0);
    check("rst/bus_req",   bus_req,   1'b0);
    check("rst/bus_wr",    bus_wr,    1'b0);
    check("rst/bus_strb",  bus_strb,  4'h0);
    check("rst/bus_addr",  bus_addr,  32'h0);
    check("rst/bus_wdata", bus_wdata, 32'h0);
    check("rst/cpu_rdata", cpu_rdata, 32'h0);
    check("rst/bus_err",   bus_err,   1'b0);
    reset = 1'b0;
    step();

    // Read, zero-wait: 3 stalled cycles, word-aligned address.
    access("rd0", 4'b0000, 32'h1000_0006, 32'h0, 32'h1000_0004, 1'b0, 0, 0,
           32'h1234_5678, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("rd0/stalls", stalls, 3);
    check("rd0/rdata",  got, 32'h1234_5678);

    // Byte write, grant on the 5th REQ cycle: 6 stalled cycles, no WAIT.
    access("wr1", 4'b0010, 32'h2000_0101, 32'hAABB_CCDD, 32'h2000_0100, 1'b1, 4, -1,
           32'h0, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("wr1/stalls",     stalls, 6);
    check("wr1/req_cycles", req_n,  5);
    check("wr1/wait_cyc",   wait_n, 0);
    check("wr1/rdata_held", got,    32'h1234_5678);

    // Grant with a spurious same-cycle response, real response 2 cycles later.
    access("same", 4'b0000, 32'h0000_0040, 32'h0, 32'h0000_0040, 1'b0, 0, 1,
           32'hCAFE_0001, 1'b1, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("same/stalls", stalls, 4);
    check("same/rdata",  got, 32'hCAFE_0001);

    // Reset while waiting for a read response.
    cpu_en   = 1'b1;
    cpu_wen  = 4'b0000;
    cpu_addr = 32'h2000_0010;
    step();
    check("rstmid/in_req", bus_req, 1'b1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("rstmid/in_wait", {bus_req, cpu_stall}, 2'b01);
    reset  = 1'b1;
    cpu_en = 1'b0;
    step();
    reset = 1'b0;
    check("rstmid/state",     dut.state_q, IDLE);
    check("rstmid/bus_req",   bus_req,   1'b0);
    check("rstmid/cpu_stall", cpu_stall, 1'b0);
    check("rstmid/cpu_rdata", cpu_rdata, 32'h0);
    check("rstmid/bus_addr",  bus_addr,  32'h0);
    access("rstmid_rd", 4'b0000, 32'h0000_0123, 32'h0, 32'h0000_0120, 1'b0, 1, 2,
           32'h7654_3210, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("rstmid_rd/stalls", stalls, 6);
    check("rstmid_rd/rdata",  got, 32'h7654_3210);

    // Back-to-back read then write: DONE, one IDLE, then REQ.
    access("b2b_rd", 4'b0000, 32'h3000_0000, 32'h0, 32'h3000_0000, 1'b0, 0, 0,
           32'h5555_AAAA, 1'b0, stalls, req_n, wait_n, got, done_cyc_a, first_req_cyc);
    check("b2b_rd/rdata", got, 32'h5555_AAAA);
    access("b2b_wr", 4'b1111, 32'h3000_0008, 32'h0102_0304, 32'h3000_0008, 1'b1, 0, -1,
           32'h0, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_b);
    check("b2b/gap",       first_req_b - done_cyc_a, 2);
    check("b2b_wr/stalls", stalls, 2);

`ifdef DATA_SRAM_BRIDGE_TIMEOUT_EN
    // Read granted, response never arrives: DONE after 8 counted cycles.
    access("tmo", 4'b0000, 32'h4000_0004, 32'h0, 32'h4000_0004, 1'b0, 0, -1,
           32'h0, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("tmo/counted", req_n + wait_n, 8);
    check("tmo/rdata",   got, 32'hDEAD_BEEF);
    check("tmo/bus_err", bus_err, 1'b1);
    step();
    step();
    check("tmo/err_sticky", bus_err, 1'b1);
    access("tmo_after", 4'b0000, 32'h4000_0008, 32'h0, 32'h4000_0008, 1'b0, 0, 0,
           32'h1111_2222, 1'b0, stalls, req_n, wait_n, got, done_cyc, first_req_cyc);
    check("tmo_after/rdata",   got, 32'h1111_2222);
    check("tmo_after/bus_err", bus_err, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("tmo/err_cleared", bus_err, 1'b0);
`else
    check("noerr/bus_err", bus_err, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
